// File: rtl/onehot_to_bin_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : onehot_to_bin_stream
//  Purpose  : Registered multi-channel one-hot to binary encoder with
//             illegal-code flagging, error counting and a 2-entry spill buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_to_bin_stream #(
  parameter int unsigned ONEHOT_WIDTH  = 16,
  parameter int unsigned NUM_CH        = 1,
  parameter int unsigned BIN_WIDTH     = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH),
  parameter bit          LOWEST_WINS   = 1'b0,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [NUM_CH*ONEHOT_WIDTH-1:0] onehot_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [NUM_CH*BIN_WIDTH-1:0]    bin_o,
  output logic [NUM_CH-1:0]              err_o,
  output logic [ERR_CNT_WIDTH-1:0]       err_cnt_o,
  input  logic                           clr_i
);

  localparam int unsigned PAYLOAD_W = NUM_CH * (BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  logic [NUM_CH*BIN_WIDTH-1:0] enc_bin;
  logic [NUM_CH-1:0]           enc_err;
  logic [PAYLOAD_W-1:0]        enc_payload;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      if (ONEHOT_WIDTH == 1) begin : g_w1
        assign enc_bin[c*BIN_WIDTH +: BIN_WIDTH] = '0;
        assign enc_err[c]                        = ~onehot_i[c];
      end else begin : g_wn
        logic [ONEHOT_WIDTH-1:0] code;
        logic [BIN_WIDTH-1:0]    bin_or;
        logic [BIN_WIDTH-1:0]    bin_low;
        logic                    seen;
        logic                    multi;

        assign code = onehot_i[c*ONEHOT_WIDTH +: ONEHOT_WIDTH];

        // Scan high-to-low so the last hit is the lowest set index.
        always_comb begin
          bin_or  = '0;
          bin_low = '0;
          seen    = 1'b0;
          multi   = 1'b0;
          for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
            if (code[i]) begin
              bin_or  = bin_or | BIN_WIDTH'(i);
              bin_low = BIN_WIDTH'(i);
              multi   = multi | seen;
              seen    = 1'b1;
            end
          end
        end

        assign enc_bin[c*BIN_WIDTH +: BIN_WIDTH] = LOWEST_WINS ? bin_low : bin_or;
        assign enc_err[c]                        = ~seen | multi;
      end
    end
  endgenerate

  assign enc_payload = {enc_bin, enc_err};

  state_e                   state_q, state_d;
  logic [PAYLOAD_W-1:0]     a_q, a_d;
  logic [PAYLOAD_W-1:0]     b_q, b_d;
  logic                     ready_q, ready_d;
  logic                     valid_q, valid_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     accept;
  logic                     pop;

  assign accept = valid_i & ready_q;
  assign pop    = valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          a_d     = enc_payload;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && !pop) begin
          b_d     = enc_payload;
          state_d = S_TWO;
        end else if (accept && pop) begin
          a_d = enc_payload;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          a_d     = b_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Handshake flags are precomputed from the next state so both ports come straight off flops.
    ready_d = (state_d != S_TWO);
    valid_d = (state_d != S_EMPTY);

    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (accept && (|enc_err) && (cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o          = ready_q;
  assign valid_o          = valid_q;
  assign {bin_o, err_o}   = a_q;
  assign err_cnt_o        = cnt_q;

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
  a_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o) |=> valid_i);
  a_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o) |=> $stable(onehot_i));
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_onehot_to_bin_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_to_bin_stream
//  Purpose  : Scoreboard bench; two encoders (OR-policy/8-bit count and
//             lowest-policy/2-bit count) share one randomized stimulus stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_to_bin_stream;

  localparam int OW = 16;
  localparam int NC = 2;
  localparam int BW = 4;

  typedef struct packed {
    logic [NC*BW-1:0] bin;
    logic [NC-1:0]    err;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           valid_i;
  logic [NC*OW-1:0] onehot_i;
  logic           ready_i;
  logic           clr_i;

  logic           ready0, valid0, ready1, valid1;
  logic [NC*BW-1:0] bin0, bin1;
  logic [NC-1:0]  err0, err1;
  logic [7:0]     cnt0_o;
  logic [1:0]     cnt1_o;

  int    checks = 0;
  int    errors = 0;
  beat_t exp0[$];
  beat_t exp1[$];
  int    m_cnt0 = 0;
  int    m_cnt1 = 0;
  logic  hold0 = 1'b0;
  logic  hold1 = 1'b0;
  logic [31:0] last0, last1;

  always #5 clk = ~clk;

  onehot_to_bin_stream #(.ONEHOT_WIDTH(OW), .NUM_CH(NC), .LOWEST_WINS(1'b0), .ERR_CNT_WIDTH(8)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready0), .onehot_i(onehot_i),
    .valid_o(valid0), .ready_i(ready_i), .bin_o(bin0), .err_o(err0), .err_cnt_o(cnt0_o), .clr_i(clr_i));

  onehot_to_bin_stream #(.ONEHOT_WIDTH(OW), .NUM_CH(NC), .LOWEST_WINS(1'b1), .ERR_CNT_WIDTH(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready1), .onehot_i(onehot_i),
    .valid_o(valid1), .ready_i(ready_i), .bin_o(bin1), .err_o(err1), .err_cnt_o(cnt1_o), .clr_i(clr_i));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a code is legal iff exactly one bit is set.
  function automatic logic [4:0] ref_ch(input logic [15:0] code, input bit lowest);
    int n, lo, orv;
    n   = $countones(code);
    lo  = -1;
    orv = 0;
    for (int i = 0; i < 16; i++) begin
      if (code[i]) begin
        if (lo < 0) lo = i;
        orv = orv | i;
      end
    end
    if (n == 0) return 5'b00001;
    if (n == 1) return {4'(lo), 1'b0};
    return {(lowest ? 4'(lo) : 4'(orv)), 1'b1};
  endfunction

  function automatic beat_t ref_beat(input logic [31:0] d, input bit lowest);
    beat_t      b;
    logic [4:0] r;
    for (int ch = 0; ch < NC; ch++) begin
      r = ref_ch(d[ch*OW +: OW], lowest);
      b.bin[ch*BW +: BW] = r[4:1];
      b.err[ch]          = r[0];
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_code(input bit legal_only);
    logic [31:0] d;
    int          k;
    for (int ch = 0; ch < NC; ch++) begin
      k = legal_only ? 0 : int'($urandom_range(0, 5));
      if (k <= 3)      d[ch*OW +: OW] = 16'h0001 << $urandom_range(0, 15);
      else if (k == 4) d[ch*OW +: OW] = 16'h0000;
      else             d[ch*OW +: OW] = 16'($urandom());
    end
    return d;
  endfunction

  // One clock of stimulus; expectations are queued at the moment of acceptance.
  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c,
                       output logic acc);
    beat_t b0, b1;
    valid_i  = v;
    onehot_i = d;
    ready_i  = r;
    clr_i    = c;
    chk("ready_match", {31'b0, ready1}, {31'b0, ready0});
    acc = v && ready0;
    b0  = ref_beat(d, 1'b0);
    b1  = ref_beat(d, 1'b1);
    if (acc) begin
      exp0.push_back(b0);
      exp1.push_back(b1);
    end
    if (c) begin
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else if (acc && (|b0.err)) begin
      if (m_cnt0 < 255) m_cnt0++;
      if (m_cnt1 < 3)   m_cnt1++;
    end
    @(posedge clk);
    #1;
    chk("err_cnt0", {24'b0, cnt0_o}, m_cnt0);
    chk("err_cnt1", {30'b0, cnt1_o}, m_cnt1);
  endtask

  task automatic send(input logic [31:0] d, input logic r, input string nm);
    logic acc;
    int   n = 0;
    do begin
      drive(1'b1, d, r, 1'b0, acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor: pops and compares on every output handshake, and checks stall stability.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (hold0) begin
          chk("hold0_valid", {31'b0, valid0}, 32'd1);
          chk("hold0_data", {22'b0, bin0, err0}, last0);
        end
        hold0 = valid0 && !ready_i;
        last0 = {22'b0, bin0, err0};
        if (valid0 && ready_i) begin
          if (exp0.size() == 0) chk("unexpected_out0", {22'b0, bin0, err0}, 32'hFFFF_FFFF);
          else begin
            e = exp0.pop_front();
            chk("out0", {22'b0, bin0, err0}, {22'b0, e});
          end
        end
        if (hold1) begin
          chk("hold1_valid", {31'b0, valid1}, 32'd1);
          chk("hold1_data", {22'b0, bin1, err1}, last1);
        end
        hold1 = valid1 && !ready_i;
        last1 = {22'b0, bin1, err1};
        if (valid1 && ready_i) begin
          if (exp1.size() == 0) chk("unexpected_out1", {22'b0, bin1, err1}, 32'hFFFF_FFFF);
          else begin
            e = exp1.pop_front();
            chk("out1", {22'b0, bin1, err1}, {22'b0, e});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic        pend;
    logic [31:0] x, y, z, pd;
    beat_t       bx;

    rst_n = 1'b0; valid_i = 1'b0; onehot_i = '0; ready_i = 1'b0; clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid0", {31'b0, valid0}, 0);
    chk("rst_ready0", {31'b0, ready0}, 1);
    chk("rst_bin0", {24'b0, bin0}, 0);
    chk("rst_err0", {30'b0, err0}, 0);
    chk("rst_cnt0", {24'b0, cnt0_o}, 0);
    chk("rst_valid1", {31'b0, valid1}, 0);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, acc);

    // Basic legal encode, 1-cycle latency
    drive(1'b1, {16'h0100, 16'h0008}, 1'b1, 1'b0, acc);
    chk("basic_acc", {31'b0, acc}, 1);
    chk("basic_latency", {31'b0, valid0}, 1);
    chk("basic_bin", {24'b0, bin0}, 32'h83);
    chk("basic_err", {30'b0, err0}, 0);
    drive(1'b0, '0, 1'b1, 1'b0, acc);

    // Zero-hot and multi-hot under both policies
    drive(1'b1, {16'h0A00, 16'h0000}, 1'b1, 1'b0, acc);
    chk("illegal_bin_or", {24'b0, bin0}, 32'hB0);
    chk("illegal_bin_low", {24'b0, bin1}, 32'h90);
    chk("illegal_err", {30'b0, err0}, 32'h3);
    chk("illegal_cnt", {24'b0, cnt0_o}, 1);
    drive(1'b0, '0, 1'b1, 1'b0, acc);

    // Backpressure: X, Y fill the buffer, Z must be held off
    x = rand_code(1'b1); y = rand_code(1'b1); z = rand_code(1'b1);
    drive(1'b1, x, 1'b0, 1'b0, acc);
    chk("bp_x_acc", {31'b0, acc}, 1);
    drive(1'b1, y, 1'b0, 1'b0, acc);
    chk("bp_y_acc", {31'b0, acc}, 1);
    chk("bp_ready_low", {31'b0, ready0}, 0);
    bx = ref_beat(x, 1'b0);
    chk("bp_head_x", {24'b0, bin0}, {24'b0, bx.bin});
    drive(1'b1, z, 1'b0, 1'b0, acc);
    chk("bp_z_held", {31'b0, acc}, 0);
    send(z, 1'b1, "bp_z");
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, acc);
    chk("bp_drain", exp0.size(), 0);

    // Full throughput with legal codes
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, rand_code(1'b1), 1'b1, 1'b0, acc);
      chk("tput_acc", {31'b0, acc}, 1);
    end
    drive(1'b0, '0, 1'b1, 1'b0, acc);
    chk("tput_drain", exp0.size(), 0);

    // Counter saturation and clear priority
    drive(1'b0, '0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 5; k++) send({rand_code(1'b0) & 32'hFFFF_0000}, 1'b1, "sat");
    chk("sat_cnt1", {30'b0, cnt1_o}, 3);
    chk("sat_cnt0", {24'b0, cnt0_o}, 5);
    drive(1'b1, 32'h0, 1'b1, 1'b1, acc);
    chk("clr_acc", {31'b0, acc}, 1);
    chk("clr_priority", {30'b0, cnt1_o}, 0);
    drive(1'b0, '0, 1'b1, 1'b0, acc);

    // Random traffic with random backpressure and occasional clears
    pend = 1'b0;
    pd   = '0;
    for (int k = 0; k < 400; k++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        pd   = rand_code(1'b0);
      end
      drive(pend, pd, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0), acc);
      if (acc) pend = 1'b0;
    end
    if (pend) send(pd, 1'b1, "rand_tail");
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0, acc);
    chk("rand_drain", exp0.size() + exp1.size(), 0);

    // Asynchronous reset while the buffer is full
    drive(1'b1, rand_code(1'b1), 1'b0, 1'b0, acc);
    drive(1'b1, 32'h0000_0003, 1'b0, 1'b0, acc);
    chk("ar_full", {31'b0, ready0}, 0);
    valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, valid0}, 0);
    chk("ar_ready", {31'b0, ready0}, 1);
    chk("ar_cnt0", {24'b0, cnt0_o}, 0);
    chk("ar_cnt1", {30'b0, cnt1_o}, 0);
    exp0.delete(); exp1.delete();
    m_cnt0 = 0; m_cnt1 = 0;
    hold0 = 1'b0; hold1 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("ar_idle", {31'b0, valid0}, 0);
    drive(1'b1, rand_code(1'b1), 1'b1, 1'b0, acc);
    chk("ar_first_acc", {31'b0, acc}, 1);
    chk("ar_latency", {31'b0, valid0}, 1);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, acc);
    chk("final_drain", exp0.size() + exp1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onehot_to_bin_stream.md
Name: onehot_to_bin_stream

Overview:
Registered, multi-channel one-hot to binary encoder with a valid/ready stream interface. Each of NUM_CH lanes is encoded in parallel. Each lane is checked for illegal codes: zero-hot, or multi-hot in the strict sense. Illegal codes are flagged per beat and counted. A 2-entry spill buffer gives full throughput, and ready_o is driven only from registers. The block sits between arbiters/grant generators and index-consuming datapaths that need a registered, checked index.

Parameters:
ONEHOT_WIDTH, 16, bits per channel one-hot code (>=1)
NUM_CH, 1, number of independent channels per beat (>=1)
BIN_WIDTH, (ONEHOT_WIDTH==1 ? 1 : $clog2(ONEHOT_WIDTH)), derived, do not override
LOWEST_WINS, 0, multi-hot policy: 0 = OR of indices of all set bits; 1 = index of lowest set bit
ERR_CNT_WIDTH, 8, width of saturating error-beat counter

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  input beat valid
ready_o  in/out: out  1  input beat accepted when valid_i & ready_o
onehot_i  in  NUM_CH*ONEHOT_WIDTH  channel c at [c*ONEHOT_WIDTH +: ONEHOT_WIDTH]
valid_o  out  1  output beat valid
ready_i  in  1  downstream ready
bin_o  out  NUM_CH*BIN_WIDTH  channel c at [c*BIN_WIDTH +: BIN_WIDTH]
err_o  out  NUM_CH  per-channel illegal-code flag, qualified by valid_o
err_cnt_o  out  ERR_CNT_WIDTH  saturating count of accepted beats with any err bit set
clr_i  in  1  synchronous clear of err_cnt_o

Behaviour:
- Clock and reset: one clock (clk_i). Reset (rst_ni) is asynchronous and active-low.
- Reset values: valid_o=0, ready_o=1, bin_o=0, err_o=0, err_cnt_o=0, spill state EMPTY. Reset mid-stream drops all buffered beats; no partial output.
- Encode (combinational, per channel, on input side):
  - Exactly one bit i set: bin=i, err=0.
  - Zero bits set: bin=0, err=1.
  - Multi-hot, LOWEST_WINS=0: bin = bitwise OR of all set indices, err=1.
  - Multi-hot, LOWEST_WINS=1: bin = lowest set index, err=1.
  - ONEHOT_WIDTH==1: bin always 0; err = ~onehot bit.
- Spill buffer, 2 entries (A=head, B=skid), each holding {bin, err} for all channels:
  - EMPTY: accept -> ONE.
  - ONE: accept & ~pop -> TWO. Accept & pop -> ONE, with A replaced by the new beat. Pop & ~accept -> EMPTY.
  - TWO: ready_o=0. Pop -> ONE, with B moved to A.
  - pop = valid_o & ready_i.
- Handshake:
  - ready_o = (state != TWO), registered.
  - valid_o = (state != EMPTY).
  - bin_o/err_o show entry A.
  - Latency: 1 cycle from accept to valid_o when empty. Throughput: 1 beat/cycle with ready_i held high.
  - Once valid_o=1, bin_o/err_o/valid_o hold stable until pop.
  - Input not accepted (valid_i & ~ready_o) is ignored; the source must hold it.
  - Beats leave strictly in order; no loss, no duplication.
- Error counter:
  - Increments by 1 on each accepted beat with |err (input side, at acceptance).
  - Saturates at 2^ERR_CNT_WIDTH-1.
  - clr_i has priority: if clr_i and an increment coincide, the counter becomes 0.
- Simulation-only checks (excluded under COMMON_CELLS_ASSERTS_OFF and translate_off):
  - valid_i must not drop without acceptance.
  - onehot_i must stay stable while valid_i & ~ready_o.
  - These are assertions; illegal codes themselves are not fatal.

Test Plan:
- Basic encode: ONEHOT_WIDTH=16, NUM_CH=2, send onehot_i={16'h0100,16'h0008} with ready_i=1 -> next cycle valid_o=1, bin_o={4'd8,4'd3}, err_o=2'b00, err_cnt_o=0.
- Illegal codes: ch0=16'h0000, ch1=16'h0A00. LOWEST_WINS=0 -> bin ch1=4'd11, err_o=2'b11. LOWEST_WINS=1 -> bin ch1=4'd9. ch0 bin=0 in both modes. err_cnt_o=1 after acceptance.
- Backpressure: ready_i=0, push 3 beats X,Y,Z -> X,Y accepted, ready_o=0 on cycle after Y, Z held. Release ready_i -> bin_o sequence X,Y,Z, one per cycle, no gaps once Z is accepted.
- Full throughput: 100 random legal beats, ready_i=1 -> 100 outputs, in order, 1/cycle, err_o=0 throughout, err_cnt_o=0.
- Counter saturation/clear: ERR_CNT_WIDTH=2, 5 illegal beats -> err_cnt_o=3. Assert clr_i in the same cycle as a 6th illegal accept -> err_cnt_o=0 next cycle.
- Async reset mid-stream: state TWO, pull rst_ni low between clock edges -> valid_o=0, ready_o=1, err_cnt_o=0 immediately. After release, the first new beat appears with 1-cycle latency.
